// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: op encodings, flag layout, entry sizing.
package alu_result_stage_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned FLAG_N  = 3;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_V  = 0;
    localparam int unsigned FLAGS_W = 4;

    // Field order matches the bit indices above: {N,Z,C,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Buffer entry is {result, flags, mismatch}.
    function automatic int unsigned entry_w(input int unsigned width);
        return width + FLAGS_W + 1;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational flag generation and result cross-check for one ALU transfer.
module alu_flag_calc
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output flags_t           flags_c_o,
    output logic             mismatch_c_o
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] expect_res;
    logic             a_msb;
    logic             b_msb;
    logic             c_msb;

    // Flags always describe the presented C; mismatch compares C against a local recompute.
    always_comb begin
        flags_c_o    = '0;
        mismatch_c_o = 1'b0;
        expect_res   = '0;
        sum_ext      = {1'b0, a_i} + {1'b0, b_i};
        diff         = a_i - b_i;
        a_msb        = a_i[WIDTH-1];
        b_msb        = b_i[WIDTH-1];
        c_msb        = c_i[WIDTH-1];

        flags_c_o.n = c_msb;
        flags_c_o.z = (c_i == '0);
        if (op_i == OP_SUB) begin
            flags_c_o.c = (a_i >= b_i);
            flags_c_o.v = (a_msb != b_msb) && (c_msb != a_msb);
            expect_res  = diff;
        end else begin
            flags_c_o.c = sum_ext[WIDTH];
            flags_c_o.v = (a_msb == b_msb) && (c_msb != a_msb);
            expect_res  = sum_ext[WIDTH-1:0];
        end
        mismatch_c_o = (c_i != expect_res);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer capturing ALU results with flags, mismatch and an overflow counter.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam int unsigned ENTRY_W = entry_w(WIDTH);

    flags_t             in_flags;
    logic               in_mismatch;
    logic [ENTRY_W-1:0] in_entry;
    logic               accept;
    logic               drain;

    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    alu_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .op_i         (in_op),
        .a_i          (in_a),
        .b_i          (in_b),
        .c_i          (in_c),
        .flags_c_o    (in_flags),
        .mismatch_c_o (in_mismatch)
    );

    assign in_entry = {in_c, in_flags, in_mismatch};
    assign accept   = in_valid & in_ready_q;
    assign drain    = main_valid_q & out_ready;

    // Next-state for the FIFO entries, the registered ready and the overflow counter.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        ovf_count_d  = ovf_count_q;

        if (drain) begin
            if (skid_valid_q) begin
                // in_ready was low, so no accept can collide with the skid refill.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_entry;
                end
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = in_entry;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = in_entry;
            end
        end

        in_ready_d = ~skid_valid_d;

        if (ovf_clr) begin
            ovf_count_d = '0;
        end else if (accept && in_flags.v && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    // State registers; reset discards both entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign out_result   = main_q[ENTRY_W-1 -: WIDTH];
    assign out_flags    = main_q[FLAGS_W:1];
    assign out_mismatch = main_q[0];
    assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench: directed vector table, handshake corner sequences, random vs. FIFO model.
module tb_alu_result_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [WIDTH-1:0]  in_a, in_b, in_c;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [3:0]        out_flags;
    logic              out_mismatch;
    logic [CNT_W-1:0]  ovf_count;
    logic              ovf_clr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_mismatch (out_mismatch),
        .ovf_count    (ovf_count),
        .ovf_clr      (ovf_clr)
    );

    typedef struct {
        logic        op;
        logic [31:0] a, b, c;
        logic [31:0] r;
        logic [3:0]  f;
        logic        m;
        int          ovf;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic        m;
    } ent_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference flags from the arithmetic definitions, using wide integers.
    function automatic logic [3:0] ref_flags(input logic op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        longint ua, ub;
        logic n, z, cy, v;
        ua = longint'(a);
        ub = longint'(b);
        n  = c[31];
        z  = (c == 32'd0);
        if (op) begin
            cy = (ua >= ub);
            v  = (a[31] != b[31]) && (c[31] != a[31]);
        end else begin
            cy = ((ua + ub) > 64'sh0000_0000_FFFF_FFFF);
            v  = (a[31] == b[31]) && (c[31] != a[31]);
        end
        return {n, z, cy, v};
    endfunction

    function automatic logic ref_mis(input logic op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] c);
        logic [31:0] t;
        t = op ? (a - b) : (a + b);
        return c != t;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [4];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h7FFF_FFFF;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_c     = c;
    endtask

    vec_t vecs [8];
    ent_t q [$];
    ent_t e;
    int   model_ovf;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;

        vecs[0] = '{1'b0, 32'd7, 32'd4, 32'd11, 32'd11, 4'b0000, 1'b0, 0};
        vecs[1] = '{1'b1, 32'd7, 32'd4, 32'd3, 32'd3, 4'b0010, 1'b0, 0};
        vecs[2] = '{1'b1, 32'd4, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 4'b1000, 1'b0, 0};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h8000_0000, 4'b1001, 1'b0, 1};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0011, 1'b0, 2};
        vecs[5] = '{1'b0, 32'd7, 32'd4, 32'd10, 32'd10, 4'b0000, 1'b1, 2};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'b0110, 1'b0, 2};
        vecs[7] = '{1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 4'b0110, 1'b0, 2};

        // Reset state.
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_result", 64'(out_result), 64'(0));
        chk("rst_flags", 64'(out_flags), 64'(0));
        chk("rst_mismatch", 64'(out_mismatch), 64'(0));
        chk("rst_ovf", 64'(ovf_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("ready_after_edge", 64'(in_ready), 64'(1));

        // Directed table, back-to-back with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].r));
            chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].f));
            chk($sformatf("vec%0d_mismatch", i), 64'(out_mismatch), 64'(vecs[i].m));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf_count), 64'(vecs[i].ovf));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("table_drained", 64'(out_valid), 64'(0));

        // Stall: three back-to-back valids with downstream blocked.
        out_ready = 1'b0;
        drive(1'b0, 32'd1, 32'd0, 32'd1);
        @(negedge clk);
        chk("stall_v1_out", 64'(out_result), 64'(1));
        chk("stall_ready1", 64'(in_ready), 64'(1));
        drive(1'b0, 32'd2, 32'd0, 32'd2);
        @(negedge clk);
        chk("stall_ready2", 64'(in_ready), 64'(0));
        drive(1'b0, 32'd3, 32'd0, 32'd3);
        @(negedge clk);
        chk("stall_hold_valid", 64'(out_valid), 64'(1));
        chk("stall_hold_result", 64'(out_result), 64'(1));
        chk("stall_ready3", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_out2", 64'(out_result), 64'(2));
        chk("stall_ready_back", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk("stall_out3", 64'(out_result), 64'(3));
        chk("stall_out3_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_drained", 64'(out_valid), 64'(0));

        // Overflow counter saturation and clear priority.
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf_count), 64'(0));
        for (int i = 0; i < 255; i++) begin
            drive(1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
            @(negedge clk);
        end
        chk("ovf_at_255", 64'(ovf_count), 64'(255));
        @(negedge clk);
        chk("ovf_saturated", 64'(ovf_count), 64'(255));
        ovf_clr = 1'b1;
        @(negedge clk);
        chk("ovf_clr_priority", 64'(ovf_count), 64'(0));
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Random traffic against a depth-2 FIFO model.
        q.delete();
        model_ovf = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic op;
            logic [31:0] a, b, c;
            logic acc, drn;
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("rnd_ovf", 64'(ovf_count), 64'(model_ovf));
            if (q.size() > 0) begin
                chk("rnd_result", 64'(out_result), 64'(q[0].r));
                chk("rnd_flags", 64'(out_flags), 64'(q[0].f));
                chk("rnd_mismatch", 64'(out_mismatch), 64'(q[0].m));
            end
            op = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            c  = op ? (a - b) : (a + b);
            if ($urandom_range(0, 9) == 0) c = $urandom;
            drive(op, a, b, c);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            e.r = c;
            e.f = ref_flags(op, a, b, c);
            e.m = ref_mis(op, a, b, c);
            if (acc) q.push_back(e);
            if (ovf_clr) model_ovf = 0;
            else if (acc && e.f[0] && model_ovf < 255) model_ovf++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        ovf_clr  = 1'b0;

        // Reset in the middle of a stall discards everything at once.
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'd9, 32'd2, 32'd7);
        @(negedge clk);
        drive(1'b1, 32'd9, 32'd3, 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_result", 64'(out_result), 64'(0));
        chk("midrst_ovf", 64'(ovf_count), 64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        chk("post_rst_ready", 64'(in_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
